// File: rtl/cpu_pkg.sv
// Shared CPU constants: register-file geometry and write-back queue sizing.
// Also defines the source-select encoding used by the write-back arbiter.
package cpu_pkg;

  localparam int CPU_DATA_W = 8;
  localparam int CPU_ADDR_W = 3;
  localparam int NUM_REGS   = 1 << CPU_ADDR_W;
  localparam int WB_DEPTH   = 4;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_MEM  = 2'd1,
    SRC_ALU  = 2'd2
  } wb_src_e;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int wb_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Pending-write queue for the write-back stage. Besides push/pop it exposes every
// slot in age order (index 0 = oldest) so the parent can compute busy flags and forwarding.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DEPTH  = WB_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [ADDR_W-1:0]         push_reg,
  input  logic [DATA_W-1:0]         push_data,
  input  logic                      pop,
  output logic [ADDR_W-1:0]         head_reg,
  output logic [DATA_W-1:0]         head_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic [DEPTH-1:0]          age_valid,
  output logic [ADDR_W-1:0]         age_reg  [DEPTH],
  output logic [DATA_W-1:0]         age_data [DEPTH]
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = wb_cnt_w(DEPTH);

  logic [ADDR_W-1:0] reg_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              do_push;
  logic              do_pop;
  logic [PTR_W-1:0]  slot;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && (count_q < CNT_W'(DEPTH));

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: occupancy alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) begin
      reg_mem[wr_ptr]  <= push_reg;
      data_mem[wr_ptr] <= push_data;
    end
  end

  assign head_reg  = reg_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];
  assign count     = count_q;

  always_comb begin
    slot = '0;
    for (int a = 0; a < DEPTH; a++) begin
      slot         = rd_ptr + PTR_W'(a);
      age_valid[a] = CNT_W'(a) < count_q;
      age_reg[a]   = reg_mem[slot];
      age_data[a]  = data_mem[slot];
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-back stage: arbitrates load and ALU results into a pending-write
// queue, drains one entry per cycle to the register file, and reports busy/forwarding.
module regfile_writeback
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DEPTH  = WB_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [ADDR_W-1:0]      alu_reg,
  input  logic [DATA_W-1:0]      alu_data,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [ADDR_W-1:0]      mem_reg,
  input  logic [DATA_W-1:0]      mem_data,
  output logic                   write_enable,
  output logic [ADDR_W-1:0]      write_reg,
  output logic [DATA_W-1:0]      write_data,
  output logic [(1<<ADDR_W)-1:0] busy,
  input  logic [ADDR_W-1:0]      fwd_reg,
  output logic                   fwd_hit,
  output logic [DATA_W-1:0]      fwd_data,
  output logic [$clog2(DEPTH):0] pending
);

  localparam int CNT_W = wb_cnt_w(DEPTH);
  localparam int NREG  = 1 << ADDR_W;

  // Handshake: a source transfers at a rising edge exactly when its valid and ready are
  // both high. Valid may be low while ready is high (no transfer). Ready depends only on
  // queue occupancy before the edge (and mem_valid for the ALU), never on a same-cycle pop.

  wb_src_e           src_sel;
  logic              push;
  logic              pop;
  logic              has_room;
  logic [ADDR_W-1:0] push_reg;
  logic [DATA_W-1:0] push_data;
  logic [ADDR_W-1:0] head_reg;
  logic [DATA_W-1:0] head_data;
  logic [CNT_W-1:0]  q_count;
  logic [DEPTH-1:0]  age_valid;
  logic [ADDR_W-1:0] age_reg  [DEPTH];
  logic [DATA_W-1:0] age_data [DEPTH];
  logic [NREG-1:0]   busy_w;
  logic              hit_w;
  logic [DATA_W-1:0] fwd_w;

  assign has_room  = !reset && (q_count < CNT_W'(DEPTH));
  assign mem_ready = has_room;
  assign alu_ready = has_room && !mem_valid;

  // Loads win over ALU results; at most one push per cycle.
  always_comb begin
    src_sel   = SRC_NONE;
    push_reg  = '0;
    push_data = '0;
    if (mem_valid && mem_ready) begin
      src_sel   = SRC_MEM;
      push_reg  = mem_reg;
      push_data = mem_data;
    end else if (alu_valid && alu_ready) begin
      src_sel   = SRC_ALU;
      push_reg  = alu_reg;
      push_data = alu_data;
    end
  end

  assign push = (src_sel != SRC_NONE);
  assign pop  = (q_count != '0);

  wb_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_reg  (push_reg),
    .push_data (push_data),
    .pop       (pop),
    .head_reg  (head_reg),
    .head_data (head_data),
    .count     (q_count),
    .age_valid (age_valid),
    .age_reg   (age_reg),
    .age_data  (age_data)
  );

  // Output stage: one write strobe per drained entry, idle cycles drop the strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_enable <= 1'b0;
      write_reg    <= '0;
      write_data   <= '0;
    end else begin
      write_enable <= pop;
      if (pop) begin
        write_reg  <= head_reg;
        write_data <= head_data;
      end
    end
  end

  assign pending = q_count + CNT_W'(write_enable);

  // Output stage is the oldest in-flight write, so queue entries (walked oldest to
  // youngest) overwrite it and the youngest match ends up winning.
  always_comb begin
    busy_w = '0;
    hit_w  = 1'b0;
    fwd_w  = '0;
    if (write_enable) begin
      busy_w[write_reg] = 1'b1;
      if (write_reg == fwd_reg) begin
        hit_w = 1'b1;
        fwd_w = write_data;
      end
    end
    for (int a = 0; a < DEPTH; a++) begin
      if (age_valid[a]) begin
        busy_w[age_reg[a]] = 1'b1;
        if (age_reg[a] == fwd_reg) begin
          hit_w = 1'b1;
          fwd_w = age_data[a];
        end
      end
    end
  end

  assign busy     = busy_w;
  assign fwd_hit  = hit_w;
  assign fwd_data = fwd_w;

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios plus randomized traffic,
// checked by a queue-level reference model and an expected-write scoreboard.
module tb_regfile_writeback;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 4;
  localparam int NREG   = 1 << ADDR_W;
  localparam int W      = ADDR_W + DATA_W;

  logic                   clk;
  logic                   reset;
  logic                   alu_valid, alu_ready;
  logic [ADDR_W-1:0]      alu_reg;
  logic [DATA_W-1:0]      alu_data;
  logic                   mem_valid, mem_ready;
  logic [ADDR_W-1:0]      mem_reg;
  logic [DATA_W-1:0]      mem_data;
  logic                   write_enable;
  logic [ADDR_W-1:0]      write_reg;
  logic [DATA_W-1:0]      write_data;
  logic [NREG-1:0]        busy;
  logic [ADDR_W-1:0]      fwd_reg;
  logic                   fwd_hit;
  logic [DATA_W-1:0]      fwd_data;
  logic [$clog2(DEPTH):0] pending;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];   // scoreboard: writes expected at the register file, in order
  logic [W-1:0] mq[$];      // model: queue contents
  logic              m_we;
  logic [ADDR_W-1:0] m_wreg;
  logic [DATA_W-1:0] m_wdata;

  regfile_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_reg      (alu_reg),
    .alu_data     (alu_data),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_reg      (mem_reg),
    .mem_data     (mem_data),
    .write_enable (write_enable),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .busy         (busy),
    .fwd_reg      (fwd_reg),
    .fwd_hit      (fwd_hit),
    .fwd_data     (fwd_data),
    .pending      (pending)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_mem(input logic v, input int r, input int d);
    mem_valid = v;
    mem_reg   = ADDR_W'(r);
    mem_data  = DATA_W'(d);
  endtask

  task automatic drive_alu(input logic v, input int r, input int d);
    alu_valid = v;
    alu_reg   = ADDR_W'(r);
    alu_data  = DATA_W'(d);
  endtask

  // ---------------- reference model ----------------
  // Queue-level behaviour: every edge the oldest queued write moves to the output
  // stage; an accepted write joins the back of the queue (load wins over ALU).
  always @(posedge clk or posedge reset) begin : model
    int n;
    logic [W-1:0] e;
    if (reset) begin
      mq.delete();
      exp_q.delete();
      m_we    = 1'b0;
      m_wreg  = '0;
      m_wdata = '0;
    end else begin
      n = mq.size();
      if (n > 0) begin
        e       = mq.pop_front();
        m_we    = 1'b1;
        m_wreg  = e[W-1:DATA_W];
        m_wdata = e[DATA_W-1:0];
      end else begin
        m_we = 1'b0;
      end
      if (mem_valid && n < DEPTH) begin
        mq.push_back({mem_reg, mem_data});
        exp_q.push_back({mem_reg, mem_data});
      end else if (alu_valid && n < DEPTH) begin
        mq.push_back({alu_reg, alu_data});
        exp_q.push_back({alu_reg, alu_data});
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : monitor
    logic            exp_mr;
    logic [NREG-1:0] exp_busy;
    logic            exp_hit;
    logic [DATA_W-1:0] exp_fd;
    logic [W-1:0]    e;
    exp_mr   = !reset && (mq.size() < DEPTH);
    exp_busy = '0;
    exp_hit  = 1'b0;
    exp_fd   = '0;
    if (m_we) exp_busy[m_wreg] = 1'b1;
    foreach (mq[i]) exp_busy[mq[i][W-1:DATA_W]] = 1'b1;
    for (int i = mq.size() - 1; i >= 0 && !exp_hit; i--) begin
      if (mq[i][W-1:DATA_W] == fwd_reg) begin
        exp_hit = 1'b1;
        exp_fd  = mq[i][DATA_W-1:0];
      end
    end
    if (!exp_hit && m_we && m_wreg == fwd_reg) begin
      exp_hit = 1'b1;
      exp_fd  = m_wdata;
    end
    chk("mem_ready", 32'(mem_ready), 32'(exp_mr));
    chk("alu_ready", 32'(alu_ready), 32'(exp_mr && !mem_valid));
    chk("write_enable", 32'(write_enable), 32'(m_we));
    chk("pending", 32'(pending), 32'(mq.size()) + 32'(m_we));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("fwd_hit", 32'(fwd_hit), 32'(exp_hit));
    chk("fwd_data", 32'(fwd_data), 32'(exp_fd));
    if (write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected_write got reg=%0h data=%0h expected no write", write_reg, write_data);
      end else begin
        e = exp_q.pop_front();
        chk("sb_write_reg", 32'(write_reg), 32'(e[W-1:DATA_W]));
        chk("sb_write_data", 32'(write_data), 32'(e[DATA_W-1:0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    drive_mem(1'b0, 0, 0);
    drive_alu(1'b0, 0, 0);
    fwd_reg = '0;
    repeat (3) tick();
    chk("rst_write_enable", 32'(write_enable), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_ready", 32'(mem_ready), 32'd0);
    chk("rst_alu_ready", 32'(alu_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("idle_mem_ready", 32'(mem_ready), 32'd1);
    tick();

    // single ALU write r3=0x0D
    fwd_reg = 3'd3;
    drive_alu(1'b1, 3, 8'h0D);
    tick();
    drive_alu(1'b0, 0, 0);
    chk("s1_busy3_queued", 32'(busy[3]), 32'd1);
    chk("s1_we_early", 32'(write_enable), 32'd0);
    tick();
    chk("s1_we", 32'(write_enable), 32'd1);
    chk("s1_reg", 32'(write_reg), 32'd3);
    chk("s1_data", 32'(write_data), 32'h0D);
    chk("s1_busy3_out", 32'(busy[3]), 32'd1);
    tick();
    chk("s1_we_done", 32'(write_enable), 32'd0);
    chk("s1_busy3_clear", 32'(busy[3]), 32'd0);
    tick();

    // simultaneous load and ALU result
    drive_mem(1'b1, 2, 8'h11);
    drive_alu(1'b1, 1, 8'h03);
    #1;
    chk("s2_mem_ready", 32'(mem_ready), 32'd1);
    chk("s2_alu_ready", 32'(alu_ready), 32'd0);
    tick();
    drive_mem(1'b0, 0, 0);
    #1;
    chk("s2_alu_ready_after", 32'(alu_ready), 32'd1);
    tick();
    drive_alu(1'b0, 0, 0);
    chk("s2_first_reg", 32'(write_reg), 32'd2);
    chk("s2_first_data", 32'(write_data), 32'h11);
    tick();
    chk("s2_second_reg", 32'(write_reg), 32'd1);
    chk("s2_second_data", 32'(write_data), 32'h03);
    tick();
    chk("s2_idle", 32'(write_enable), 32'd0);

    // five back-to-back writes emerge in order
    for (int i = 0; i < 5; i++) begin
      drive_alu(1'b1, i, 8'hA0 + i);
      tick();
      if (i > 0) chk("s3_order", 32'(write_reg), 32'(i - 1));
    end
    drive_alu(1'b0, 0, 0);
    tick();
    chk("s3_last_reg", 32'(write_reg), 32'd4);
    chk("s3_last_data", 32'(write_data), 32'hA4);
    tick();
    chk("s3_idle", 32'(write_enable), 32'd0);

    // forwarding picks the youngest write to r2
    fwd_reg = 3'd2;
    drive_mem(1'b1, 2, 8'h11);
    tick();
    drive_mem(1'b1, 2, 8'h22);
    tick();
    drive_mem(1'b0, 0, 0);
    #1;
    chk("s4_fwd_hit", 32'(fwd_hit), 32'd1);
    chk("s4_fwd_data", 32'(fwd_data), 32'h22);
    tick();
    tick();
    chk("s4_fwd_hit_drained", 32'(fwd_hit), 32'd0);
    chk("s4_busy2_drained", 32'(busy[2]), 32'd0);

    // reset with writes in flight
    fwd_reg = 3'd7;
    for (int i = 5; i < 8; i++) begin
      drive_alu(1'b1, i, 8'h50 + i);
      tick();
    end
    drive_alu(1'b0, 0, 0);
    reset = 1'b1;
    #1;
    chk("s5_we", 32'(write_enable), 32'd0);
    chk("s5_reg", 32'(write_reg), 32'd0);
    chk("s5_data", 32'(write_data), 32'd0);
    chk("s5_pending", 32'(pending), 32'd0);
    chk("s5_busy", 32'(busy), 32'd0);
    chk("s5_fwd_hit", 32'(fwd_hit), 32'd0);
    chk("s5_mem_ready", 32'(mem_ready), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("s5_no_we_1", 32'(write_enable), 32'd0);
    tick();
    chk("s5_no_we_2", 32'(write_enable), 32'd0);
    chk("s5_pending_after", 32'(pending), 32'd0);

    // randomized traffic with occasional resets
    for (int c = 0; c < 600; c++) begin
      drive_mem($urandom_range(0, 99) < 35, $urandom_range(0, NREG - 1), $urandom_range(0, 255));
      drive_alu($urandom_range(0, 99) < 55, $urandom_range(0, NREG - 1), $urandom_range(0, 255));
      fwd_reg = ADDR_W'($urandom_range(0, NREG - 1));
      reset   = ($urandom_range(0, 149) == 0);
      tick();
    end
    reset = 1'b0;
    drive_mem(1'b0, 0, 0);
    drive_alu(1'b0, 0, 0);
    repeat (DEPTH + 3) tick();
    chk("drain_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_pending", 32'(pending), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
